// File: rtl/dma_copy_pkg.sv
// Shared definitions for the dma_copy word-copy engine: FSM states, register map,
// CTRL/STATUS bit positions and the byte-lane merge helper.
package dma_copy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RGAP,
        ST_WRITE,
        ST_WGAP
    } state_e;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_CLR_DONE = 1;
    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_DONE     = 1;

    function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrb);
        logic [31:0] r;
        for (int unsigned i = 0; i < 4; i++) begin
            r[i*8 +: 8] = wstrb[i] ? wdata[i*8 +: 8] : old[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dma_copy_regs.sv
// Responder side of dma_copy: one-cycle ready handshake, byte-lane SRC/DST/LEN
// registers, registered read mux, and START / CLR_DONE command pulses.
module dma_copy_regs
    import dma_copy_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             valid_i,
    input  logic [3:0]       wstrb_i,
    input  logic [31:0]      wdata_i,
    input  logic [1:0]       addr_i,
    input  logic             busy_i,
    input  logic             done_i,
    output logic             ready_o,
    output logic [31:0]      rdata_o,
    output logic [31:0]      src_o,
    output logic [31:0]      dst_o,
    output logic [LEN_W-1:0] len_o,
    output logic             start_o,
    output logic             clr_done_o
);

    logic             rdy_q;
    logic [31:0]      rdata_q;
    logic [31:0]      src_q, dst_q;
    logic [LEN_W-1:0] len_q;
    logic             accept, wr, wr_cfg, wr_ctrl;
    logic [31:0]      rd_mux, src_wr, dst_wr, len_wr;

    assign accept  = valid_i & enable_i & ~rdy_q;
    assign wr      = accept & (wstrb_i != '0);
    assign wr_cfg  = wr & ~busy_i;
    assign wr_ctrl = wr & (addr_i == REG_CTRL) & wstrb_i[0];

    assign start_o    = wr_ctrl & wdata_i[CTRL_START] & ~busy_i;
    assign clr_done_o = wr_ctrl & wdata_i[CTRL_CLR_DONE];

    // Address registers keep bits [1:0] at zero so reads and working copies stay aligned.
    assign src_wr = lane_merge(src_q, wdata_i, wstrb_i) & 32'hFFFF_FFFC;
    assign dst_wr = lane_merge(dst_q, wdata_i, wstrb_i) & 32'hFFFF_FFFC;
    assign len_wr = lane_merge(32'(len_q), wdata_i, wstrb_i);

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            REG_SRC: rd_mux = src_q;
            REG_DST: rd_mux = dst_q;
            REG_LEN: rd_mux = 32'(len_q);
            default: begin
                rd_mux[STAT_BUSY] = busy_i;
                rd_mux[STAT_DONE] = done_i;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_q   <= 1'b0;
            rdata_q <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
        end else begin
            rdy_q <= accept;
            if (accept) rdata_q <= rd_mux;
            if (wr_cfg && addr_i == REG_SRC) src_q <= src_wr;
            if (wr_cfg && addr_i == REG_DST) dst_q <= dst_wr;
            if (wr_cfg && addr_i == REG_LEN) len_q <= len_wr[LEN_W-1:0];
        end
    end

    assign ready_o = rdy_q & enable_i;
    assign rdata_o = ready_o ? rdata_q : '0;
    assign src_o   = src_q;
    assign dst_o   = dst_q;
    assign len_o   = len_q;

endmodule

// File: rtl/dma_copy.sv
// dma_copy top: copy FSM and native-bus initiator port around dma_copy_regs.
// Optional feature macro: DMA_COPY_IRQ_EN adds the irq completion output.
module dma_copy
    import dma_copy_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_instr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    output logic [31:0] m_addr,
    input  logic [31:0] m_rdata
`ifdef DMA_COPY_IRQ_EN
    ,
    output logic        irq
`endif
);

    state_e           state_q, state_d;
    logic [31:0]      src_q, dst_q, buf_q;
    logic [LEN_W-1:0] cnt_q;
    logic             done_q;
    logic             busy, last_word, start, clr_done;
    logic [31:0]      cfg_src, cfg_dst;
    logic [LEN_W-1:0] cfg_len;
    logic             unused_ok;

    assign busy      = (state_q != ST_IDLE);
    assign last_word = (cnt_q == LEN_W'(1));
    assign unused_ok = &{1'b0, mem_instr, mem_addr[31:4], mem_addr[1:0]};

    dma_copy_regs #(.LEN_W(LEN_W)) u_regs (
        .clk_i      (clk),
        .rst_ni     (resetn),
        .enable_i   (enable),
        .valid_i    (mem_valid),
        .wstrb_i    (mem_wstrb),
        .wdata_i    (mem_wdata),
        .addr_i     (mem_addr[3:2]),
        .busy_i     (busy),
        .done_i     (done_q),
        .ready_o    (mem_ready),
        .rdata_o    (mem_rdata),
        .src_o      (cfg_src),
        .dst_o      (cfg_dst),
        .len_o      (cfg_len),
        .start_o    (start),
        .clr_done_o (clr_done)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && cfg_len != '0) state_d = ST_READ;
            ST_READ:  if (m_ready) state_d = ST_RGAP;
            ST_RGAP:  state_d = ST_WRITE;
            ST_WRITE: if (m_ready) state_d = ST_WGAP;
            ST_WGAP:  state_d = last_word ? ST_IDLE : ST_READ;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_valid = 1'b0;
        m_wstrb = '0;
        m_wdata = '0;
        m_addr  = '0;
        case (state_q)
            ST_READ: begin
                m_valid = 1'b1;
                m_addr  = src_q;
            end
            ST_WRITE: begin
                m_valid = 1'b1;
                m_addr  = dst_q;
                m_wstrb = 4'hF;
                m_wdata = buf_q;
            end
            default: ;
        endcase
    end

    assign m_instr = 1'b0;

    // START is only issued from IDLE, so it never collides with the WGAP updates.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            src_q  <= '0;
            dst_q  <= '0;
            buf_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            if (start) begin
                src_q  <= cfg_src;
                dst_q  <= cfg_dst;
                cnt_q  <= cfg_len;
                done_q <= (cfg_len == '0);
            end else if (state_q == ST_WGAP && last_word) begin
                done_q <= 1'b1;
            end else if (clr_done) begin
                done_q <= 1'b0;
            end
            if (state_q == ST_READ && m_ready) buf_q <= m_rdata;
            if (state_q == ST_WGAP) begin
                src_q <= src_q + 32'd4;
                dst_q <= dst_q + 32'd4;
                cnt_q <= cnt_q - LEN_W'(1);
            end
        end
    end

`ifdef DMA_COPY_IRQ_EN
    assign irq = done_q;
`endif

endmodule
